mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: REG_AW, default 5, register-address width for rd1/rd2/wr.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 instr  input  32  MIPS instruction word.
REQ-005 instr_valid  input  1  instr is valid this cycle.
REQ-006 instr_ready  output  1  controller can accept an instruction.
REQ-007 alu_zero  input  1  zero flag from the datapath ALU.
REQ-008 alu_overflow  input  1  signed-overflow flag from the datapath ALU.
REQ-009 alu_carry  input  1  carry flag, registered into status only.
REQ-010 rd1  output  REG_AW  register-file read address 1, taken from rs.
REQ-011 rd2  output  REG_AW  register-file read address 2, taken from rt.
REQ-012 wr  output  REG_AW  write address: rd for R-type, rt for I-type.
REQ-013 op  output  4  ALU operation code.
REQ-014 sel  output  1  operand-B mux select: 0=register, 1=immediate.
REQ-015 inm  output  16  immediate field instr[15:0].
REQ-016 reg_we  output  1  register-file write enable, single-cycle pulse.
REQ-017 done  output  1  instruction retired, single-cycle pulse.
REQ-018 branch_taken  output  1  beq resolved taken; valid with done.
REQ-019 illegal  output  1  unsupported opcode/funct; valid with done.
REQ-020 exc  output  1  overflow trap (see REQ-036); valid with done.
REQ-021 carry_q  output  1  alu_carry sampled in EXEC.

Function
REQ-022 FSM states: IDLE, DECODE, EXEC, WB; transitions IDLE->DECODE on handshake, DECODE->EXEC, EXEC->WB, WB->IDLE, all unconditional except the handshake.
REQ-023 instr_ready = 1 only in IDLE; handshake = instr_valid && instr_ready; instr is captured into an internal register on handshake.
REQ-024 instr_valid outside IDLE is ignored; instr changes outside IDLE have no effect.
REQ-025 Latency: handshake at cycle N -> decoded controls valid from N+1; alu flags sampled at end of N+2; reg_we/done at N+3; next accept at N+4.
REQ-026 rd1, rd2, wr, op, sel, inm are registered and held stable from DECODE until the next handshake.
REQ-027 ALU codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12.
REQ-028 R-type (opcode 0x00), funct->op: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT; sel=0; wr=rd.
REQ-029 I-type: 0x08 addi ADD, 0x0C andi AND, 0x0D ori OR, 0x0A slti SLT; sel=1; wr=rt.
REQ-030 beq (0x04): op=SUB, sel=0, no register write; branch_taken = alu_zero sampled in EXEC.
REQ-031 reg_we in WB = 1 for legal R/I arithmetic, 0 for beq, illegal, or trapped instructions.
REQ-032 Any other opcode or funct: illegal=1 with done, reg_we=0, op=ADD, sel=0.
REQ-033 done, branch_taken, illegal, exc are 1 only in the WB cycle and 0 otherwise.
REQ-034 Instruction 0x00000000 (sll $0) is decoded as illegal.

Reset
REQ-035 rst_n low asynchronously forces IDLE; the instruction register, rd1, rd2, wr, op, sel, inm, reg_we, done, branch_taken, illegal, exc, carry_q = 0; instr_ready = 1 while rst_n is low and after release. Reset in DECODE, EXEC or WB aborts the instruction; no reg_we or done is produced.

Configuration
REQ-036 Macro OVF_TRAP_EN defined: for ADD, SUB, addi with alu_overflow=1 in EXEC, WB has reg_we=0 and exc=1. Undefined: overflow is ignored, reg_we follows REQ-031, exc is tied to 0.

Structure
REQ-037 Package mc_pkg holds ALU code constants, opcode/funct constants, and the state enum.
REQ-038 One sub-module mc_decode (combinational: instr -> op, sel, wr select, is_beq, is_illegal) is instantiated by mc_control.

Verification
REQ-039 0x00221820 (add $3,$1,$2) -> rd1=1, rd2=2, wr=3, op=2, sel=0; reg_we=1 and done=1 at N+3.
REQ-040 0x2085FFFF (addi $5,$4,-1) -> rd1=4, wr=5, sel=1, inm=0xFFFF, op=2, reg_we=1.
REQ-041 0x10220004 (beq) with alu_zero=1 -> branch_taken=1, reg_we=0; with alu_zero=0 -> branch_taken=0.
REQ-042 0xFC000000 -> illegal=1 with done, reg_we=0; the next instruction is accepted at N+4.
REQ-043 add with alu_overflow=1 -> OVF_TRAP_EN defined: exc=1, reg_we=0; undefined: exc=0, reg_we=1.
REQ-044 rst_n low during EXEC -> outputs 0 immediately, instr_ready=1, no done; a fresh instruction completes normally after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the MIPS-subset controller: ALU codes, opcodes, functs, FSM states.
package mc_pkg;

    localparam logic [3:0] AluAnd = 4'd0;
    localparam logic [3:0] AluOr  = 4'd1;
    localparam logic [3:0] AluAdd = 4'd2;
    localparam logic [3:0] AluSub = 4'd6;
    localparam logic [3:0] AluSlt = 4'd7;
    localparam logic [3:0] AluNor = 4'd12;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExec,
        StWb
    } state_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: ALU op, operand select, write-address select and class flags.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       sel,
    output logic       wr_rd,
    output logic       is_beq,
    output logic       is_illegal,
    output logic       is_ovf
);

    always_comb begin
        op         = AluAdd;
        sel        = 1'b0;
        wr_rd      = 1'b0;
        is_beq     = 1'b0;
        is_illegal = 1'b0;
        is_ovf     = 1'b0;
        case (opcode)
            OpRtype: begin
                wr_rd = 1'b1;
                case (funct)
                    FnAdd: begin
                        op     = AluAdd;
                        is_ovf = 1'b1;
                    end
                    FnSub: begin
                        op     = AluSub;
                        is_ovf = 1'b1;
                    end
                    FnAnd:   op = AluAnd;
                    FnOr:    op = AluOr;
                    FnNor:   op = AluNor;
                    FnSlt:   op = AluSlt;
                    default: is_illegal = 1'b1;
                endcase
            end
            OpAddi: begin
                op     = AluAdd;
                sel    = 1'b1;
                is_ovf = 1'b1;
            end
            OpAndi: begin
                op  = AluAnd;
                sel = 1'b1;
            end
            OpOri: begin
                op  = AluOr;
                sel = 1'b1;
            end
            OpSlti: begin
                op  = AluSlt;
                sel = 1'b1;
            end
            OpBeq: begin
                op     = AluSub;
                is_beq = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Four-state MIPS-subset controller (IDLE/DECODE/EXEC/WB) with registered control outputs.
// Optional OVF_TRAP_EN: signed overflow on add/sub/addi suppresses the write and raises exc.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    output logic [REG_AW-1:0] rd1,
    output logic [REG_AW-1:0] rd2,
    output logic [REG_AW-1:0] wr,
    output logic [3:0]        op,
    output logic              sel,
    output logic [15:0]       inm,
    output logic              reg_we,
    output logic              done,
    output logic              branch_taken,
    output logic              illegal,
    output logic              exc,
    output logic              carry_q
);

    state_e            state_q;
    logic [31:0]       instr_q;
    logic [REG_AW-1:0] wr_q;
    logic [3:0]        op_q;
    logic              sel_q;
    logic              reg_we_q;
    logic              done_q;
    logic              branch_q;
    logic              illegal_q;
    logic              exc_q;

    logic [31:0] dec_instr;
    logic [3:0]  dec_op;
    logic        dec_sel;
    logic        dec_wr_rd;
    logic        dec_beq;
    logic        dec_illegal;
    logic        dec_ovf;
    logic        trap;

    // In IDLE the decoder sees the incoming word; afterwards it re-decodes the held copy.
    assign dec_instr = (state_q == StIdle) ? instr : instr_q;

    mc_decode u_decode (
        .opcode     (dec_instr[31:26]),
        .funct      (dec_instr[5:0]),
        .op         (dec_op),
        .sel        (dec_sel),
        .wr_rd      (dec_wr_rd),
        .is_beq     (dec_beq),
        .is_illegal (dec_illegal),
        .is_ovf     (dec_ovf)
    );

`ifdef OVF_TRAP_EN
    assign trap = dec_ovf & alu_overflow;
`else
    logic unused_ovf;
    assign unused_ovf = dec_ovf ^ alu_overflow;
    assign trap       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            wr_q      <= '0;
            op_q      <= '0;
            sel_q     <= 1'b0;
            reg_we_q  <= 1'b0;
            done_q    <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            exc_q     <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            reg_we_q  <= 1'b0;
            done_q    <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            exc_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        state_q <= StDecode;
                        instr_q <= instr;
                        op_q    <= dec_op;
                        sel_q   <= dec_sel;
                        wr_q    <= dec_wr_rd ? REG_AW'(instr[15:11]) : REG_AW'(instr[20:16]);
                    end
                end
                StDecode: state_q <= StExec;
                StExec: begin
                    state_q   <= StWb;
                    carry_q   <= alu_carry;
                    done_q    <= 1'b1;
                    branch_q  <= dec_beq & alu_zero;
                    illegal_q <= dec_illegal;
                    exc_q     <= trap;
                    reg_we_q  <= ~dec_beq & ~dec_illegal & ~trap;
                end
                StWb:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign instr_ready  = (state_q == StIdle);
    assign rd1          = REG_AW'(instr_q[25:21]);
    assign rd2          = REG_AW'(instr_q[20:16]);
    assign inm          = instr_q[15:0];
    assign wr           = wr_q;
    assign op           = op_q;
    assign sel          = sel_q;
    assign reg_we       = reg_we_q;
    assign done         = done_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;
    assign exc          = exc_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: cycle-phase reference model plus directed literal checks.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_zero, alu_overflow, alu_carry;
    logic [4:0]  rd1, rd2, wr;
    logic [3:0]  op;
    logic        sel;
    logic [15:0] inm;
    logic        reg_we, done, branch_taken, illegal, exc, carry_q;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mc_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .rd1          (rd1),
        .rd2          (rd2),
        .wr           (wr),
        .op           (op),
        .sel          (sel),
        .inm          (inm),
        .reg_we       (reg_we),
        .done         (done),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .exc          (exc),
        .carry_q      (carry_q)
    );

    // Instruction-set table: what each word means for op/sel/wr and its class.
    function automatic void spec_decode(input logic [31:0] w, output logic [3:0] e_op,
                                        output logic e_sel, output logic [4:0] e_wr,
                                        output logic legal, output logic beq,
                                        output logic ovf);
        logic [5:0] opc;
        logic [5:0] fn;
        opc   = w[31:26];
        fn    = w[5:0];
        e_op  = 4'd2;
        e_sel = 1'b0;
        legal = 1'b1;
        beq   = 1'b0;
        ovf   = 1'b0;
        e_wr  = (opc == 6'h00) ? w[15:11] : w[20:16];
        case (opc)
            6'h00: begin
                case (fn)
                    6'h20: begin e_op = 4'd2; ovf = 1'b1; end
                    6'h22: begin e_op = 4'd6; ovf = 1'b1; end
                    6'h24: e_op = 4'd0;
                    6'h25: e_op = 4'd1;
                    6'h27: e_op = 4'd12;
                    6'h2A: e_op = 4'd7;
                    default: legal = 1'b0;
                endcase
            end
            6'h08: begin e_op = 4'd2; e_sel = 1'b1; ovf = 1'b1; end
            6'h0C: begin e_op = 4'd0; e_sel = 1'b1; end
            6'h0D: begin e_op = 4'd1; e_sel = 1'b1; end
            6'h0A: begin e_op = 4'd7; e_sel = 1'b1; end
            6'h04: begin e_op = 4'd6; beq = 1'b1; end
            default: legal = 1'b0;
        endcase
    endfunction

    // Reference model: counts cycles since the accepted instruction (0 = waiting).
    int          m_phase = 0;
    logic        m_has   = 1'b0;
    logic [31:0] m_instr = '0;
    logic        m_zero  = 1'b0;
    logic        m_ovf   = 1'b0;
    logic        m_carry = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_has   = 1'b0;
            m_instr = '0;
            m_carry = 1'b0;
        end else if (m_phase == 0) begin
            if (instr_valid) begin
                m_phase = 1;
                m_has   = 1'b1;
                m_instr = instr;
            end
        end else begin
            if (m_phase == 2) begin
                m_zero  = alu_zero;
                m_ovf   = alu_overflow;
                m_carry = alu_carry;
            end
            m_phase = (m_phase + 1) % 4;
        end
    end

    always @(negedge clk) begin
        logic [3:0]  e_op;
        logic        e_sel, lg, bq, ov, trap, wb;
        logic [4:0]  e_wr;
        logic [42:0] exp_v, act_v;
        spec_decode(m_instr, e_op, e_sel, e_wr, lg, bq, ov);
        if (!m_has) begin
            e_op  = '0;
            e_sel = 1'b0;
            e_wr  = '0;
        end
`ifdef OVF_TRAP_EN
        trap = ov & m_ovf;
`else
        trap = 1'b0;
`endif
        wb    = (m_phase == 3);
        exp_v = {m_phase == 0, m_instr[25:21], m_instr[20:16], e_wr, e_op, e_sel,
                 m_instr[15:0], wb & lg & ~bq & ~trap, wb, wb & bq & m_zero, wb & ~lg,
                 wb & trap, m_carry};
        act_v = {instr_ready, rd1, rd2, wr, op, sel, inm, reg_we, done, branch_taken,
                 illegal, exc, carry_q};
        checks++;
        if (act_v === exp_v) passes++;
        else $display("FAIL model_cycle t=%0t phase=%0d got=%h want=%h", $time, m_phase,
                      act_v, exp_v);
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s got=%h want=%h", name, act, want);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge inside DECODE.
    task automatic issue(input logic [31:0] w, input logic z, input logic o, input logic c);
        instr        = w;
        instr_valid  = 1'b1;
        alu_zero     = z;
        alu_overflow = o;
        alu_carry    = c;
        @(negedge clk);
        instr = 32'h0064_2820;
    endtask

    task automatic run(input logic [31:0] w, input logic z, input logic o, input logic c);
        issue(w, z, o, c);
        step(2);
        instr_valid = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n        = 1'b0;
        instr        = '0;
        instr_valid  = 1'b0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        step(2);
        lit("reset_ready", 32'(instr_ready), 32'd1);
        lit("reset_done", 32'(done), 32'd0);
        lit("reset_op", 32'(op), 32'd0);
        rst_n = 1'b1;
        step(1);
        lit("post_reset_ready", 32'(instr_ready), 32'd1);

        // add $3,$1,$2
        issue(32'h0022_1820, 1'b0, 1'b0, 1'b1);
        lit("add_rd1", 32'(rd1), 32'd1);
        lit("add_rd2", 32'(rd2), 32'd2);
        lit("add_wr", 32'(wr), 32'd3);
        lit("add_op", 32'(op), 32'd2);
        lit("add_sel", 32'(sel), 32'd0);
        lit("add_ready_busy", 32'(instr_ready), 32'd0);
        step(1);
        lit("add_no_done_exec", 32'(done), 32'd0);
        step(1);
        lit("add_done", 32'(done), 32'd1);
        lit("add_reg_we", 32'(reg_we), 32'd1);
        lit("add_carry", 32'(carry_q), 32'd1);
        instr_valid = 1'b0;
        step(1);
        lit("add_done_clear", 32'(done), 32'd0);

        // addi $5,$4,-1
        issue(32'h2085_FFFF, 1'b0, 1'b0, 1'b0);
        lit("addi_rd1", 32'(rd1), 32'd4);
        lit("addi_wr", 32'(wr), 32'd5);
        lit("addi_sel", 32'(sel), 32'd1);
        lit("addi_inm", 32'(inm), 32'h0000_FFFF);
        lit("addi_op", 32'(op), 32'd2);
        step(2);
        lit("addi_reg_we", 32'(reg_we), 32'd1);
        instr_valid = 1'b0;
        step(1);

        // beq taken / not taken
        issue(32'h1022_0004, 1'b1, 1'b0, 1'b0);
        step(2);
        lit("beq_taken", 32'(branch_taken), 32'd1);
        lit("beq_reg_we", 32'(reg_we), 32'd0);
        instr_valid = 1'b0;
        step(1);
        issue(32'h1022_0004, 1'b0, 1'b0, 1'b0);
        step(2);
        lit("beq_not_taken", 32'(branch_taken), 32'd0);
        lit("beq_done", 32'(done), 32'd1);
        instr_valid = 1'b0;
        step(1);

        // illegal opcode, next instruction held valid from WB onward
        issue(32'hFC00_0000, 1'b0, 1'b0, 1'b0);
        step(2);
        lit("illegal_flag", 32'(illegal), 32'd1);
        lit("illegal_done", 32'(done), 32'd1);
        lit("illegal_reg_we", 32'(reg_we), 32'd0);
        lit("illegal_op", 32'(op), 32'd2);
        instr = 32'h0022_1820;
        step(1);
        lit("next_ready_n4", 32'(instr_ready), 32'd1);
        step(1);
        lit("next_accepted", 32'(instr_ready), 32'd0);
        lit("next_wr", 32'(wr), 32'd3);
        step(2);
        instr_valid = 1'b0;
        step(1);

        // add with overflow
        issue(32'h0022_1820, 1'b0, 1'b1, 1'b0);
        step(2);
`ifdef OVF_TRAP_EN
        lit("ovf_exc", 32'(exc), 32'd1);
        lit("ovf_reg_we", 32'(reg_we), 32'd0);
`else
        lit("ovf_exc", 32'(exc), 32'd0);
        lit("ovf_reg_we", 32'(reg_we), 32'd1);
`endif
        instr_valid = 1'b0;
        step(1);

        // sll $0 is illegal
        issue(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        step(2);
        lit("sll0_illegal", 32'(illegal), 32'd1);
        instr_valid = 1'b0;
        step(1);

        // model-checked sweep of the remaining encodings
        run(32'h0022_1822, 1'b0, 1'b1, 1'b0);
        run(32'h0022_1824, 1'b0, 1'b1, 1'b1);
        run(32'h0022_1825, 1'b1, 1'b0, 1'b0);
        run(32'h0022_1827, 1'b0, 1'b0, 1'b1);
        run(32'h0022_182A, 1'b0, 1'b0, 1'b0);
        run(32'h3085_00FF, 1'b0, 1'b1, 1'b0);
        run(32'h3485_1234, 1'b0, 1'b0, 1'b0);
        run(32'h2885_8000, 1'b0, 1'b0, 1'b1);
        run(32'h2085_0007, 1'b0, 1'b1, 1'b0);
        run(32'h0022_1821, 1'b0, 1'b0, 1'b0);

        // reset during EXEC aborts the instruction
        issue(32'h0022_1820, 1'b0, 1'b0, 1'b1);
        step(1);
        #2;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        lit("abort_ready", 32'(instr_ready), 32'd1);
        lit("abort_rd1", 32'(rd1), 32'd0);
        lit("abort_wr", 32'(wr), 32'd0);
        step(2);
        lit("abort_no_done", 32'(done), 32'd0);
        lit("abort_no_we", 32'(reg_we), 32'd0);
        rst_n = 1'b1;
        step(1);
        issue(32'h0022_1820, 1'b0, 1'b0, 1'b0);
        step(2);
        lit("after_abort_done", 32'(done), 32'd1);
        lit("after_abort_we", 32'(reg_we), 32'd1);
        instr_valid = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
